// File: rtl/spi_master.sv
// Byte-oriented SPI mode-0 master: one full-duplex byte per valid/ready handshake,
// with programmable sclk divider and slave-select setup/hold spacing.
module spi_master #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       ss,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] HOLD  = 2'd3;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] SETUP_LD = 8'(CS_SETUP);
   localparam logic [7:0] HOLD_LD  = 8'(CS_HOLD);
   localparam logic       FAST_DIV = 1'(CLK_DIV == 1);

   logic [1:0] state_r;
   logic [7:0] cnt_r;
   logic [7:0] div_r;
   logic [3:0] edge_r;
   logic [7:0] tx_sh_r;
   logic [7:0] rx_sh_r;

   assign tx_ready = (state_r == IDLE);
   assign busy     = (state_r != IDLE);

   // Frame sequencer: select, clock generation, shifting and completion pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= IDLE;
         cnt_r    <= 8'd0;
         div_r    <= 8'd0;
         edge_r   <= 4'd0;
         tx_sh_r  <= 8'd0;
         rx_sh_r  <= 8'd0;
         rx_data  <= 8'd0;
         rx_valid <= 1'b0;
         ss       <= 1'b1;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               if (tx_valid) begin
                  tx_sh_r <= tx_data;
                  rx_sh_r <= 8'd0;
                  ss      <= 1'b0;
                  mosi    <= tx_data[7];
                  cnt_r   <= SETUP_LD;
                  div_r   <= 8'd0;
                  edge_r  <= 4'd0;
                  state_r <= SETUP;
               end else begin
                  state_r <= IDLE;
               end
            end
            SETUP: begin
               // The last setup cycle is also the first cycle of the opening
               // half-period, so with a divide of 1 the first rise lands here.
               if (cnt_r == 8'd1) begin
                  state_r <= SHIFT;
                  if (FAST_DIV) begin
                     sclk    <= 1'b1;
                     edge_r  <= 4'd1;
                     div_r   <= 8'd0;
                     rx_sh_r <= {rx_sh_r[6:0], miso};
                  end else begin
                     div_r  <= 8'd1;
                     edge_r <= 4'd0;
                  end
               end else begin
                  cnt_r <= cnt_r - 8'd1;
               end
            end
            SHIFT: begin
               if (div_r == DIV_LAST) begin
                  div_r  <= 8'd0;
                  sclk   <= ~sclk;
                  edge_r <= edge_r + 4'd1;
                  if (!sclk) begin
                     rx_sh_r <= {rx_sh_r[6:0], miso};
                  end else if (edge_r == 4'd15) begin
                     cnt_r   <= HOLD_LD;
                     state_r <= HOLD;
                  end else begin
                     mosi    <= tx_sh_r[6];
                     tx_sh_r <= {tx_sh_r[6:0], 1'b0};
                  end
               end else begin
                  div_r <= div_r + 8'd1;
               end
            end
            HOLD: begin
               if (cnt_r == 8'd1) begin
                  ss       <= 1'b1;
                  rx_data  <= rx_sh_r;
                  rx_valid <= 1'b1;
                  mosi     <= 1'b0;
                  state_r  <= IDLE;
               end else begin
                  cnt_r <= cnt_r - 8'd1;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: default-parameter instance against a slave model,
// plus a divide-by-1 instance with miso looped back to mosi.
module tb_spi_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       ss;
   logic       sclk;
   logic       mosi;
   logic       miso;

   logic [7:0] tx_data1;
   logic       tx_valid1;
   logic       tx_ready1;
   logic [7:0] rx_data1;
   logic       rx_valid1;
   logic       busy1;
   logic       ss1;
   logic       sclk1;
   logic       mosi1;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   spi_master dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .ss(ss), .sclk(sclk),
      .mosi(mosi), .miso(miso)
   );

   spi_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) dut1 (
      .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
      .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1), .ss(ss1), .sclk(sclk1),
      .mosi(mosi1), .miso(mosi1)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Slave model: presents sbyte MSB first, advancing after each sclk rise;
   // also records mosi as seen at each rise.
   logic [7:0] sbyte    = 8'h00;
   logic [3:0] rise_cnt = 4'd0;
   logic [7:0] cap      = 8'h00;
   always @(posedge sclk or negedge ss) begin
      if (sclk) begin
         rise_cnt <= rise_cnt + 4'd1;
         cap      <= {cap[6:0], mosi};
      end else begin
         rise_cnt <= 4'd0;
      end
   end
   assign miso = (rise_cnt < 4'd8) ? sbyte[3'd7 - rise_cnt[2:0]] : 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int t0;
      int n;
      int ss_low;
      int pulses;

      rst       = 1'b0;
      tx_data   = 8'h00;
      tx_valid  = 1'b0;
      tx_data1  = 8'h00;
      tx_valid1 = 1'b0;

      // ---- reset with random inputs ----
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         tx_data  = 8'($urandom);
         tx_valid = 1'($urandom);
         tx_data1 = 8'($urandom);
         tx_valid1 = 1'($urandom);
      end
      @(negedge clk);
      check("rst_ss", 32'(ss), 32'd1);
      check("rst_sclk", 32'(sclk), 32'd0);
      check("rst_mosi", 32'(mosi), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'h00);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst1_idle", {28'd0, ss1, sclk1, busy1, tx_ready1}, 32'b1001);
      tx_valid  = 1'b0;
      tx_valid1 = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // ---- single byte 0xA5, slave returns 0x3C ----
      sbyte    = 8'h3C;
      tx_data  = 8'hA5;
      tx_valid = 1'b1;
      @(negedge clk);
      t0 = cyc;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      check("accept_ss", 32'(ss), 32'd0);
      check("accept_mosi_bit7", 32'(mosi), 32'd1);
      check("accept_busy_ready", {30'd0, busy, tx_ready}, 32'b10);
      ss_low = 1;
      n = 0;
      while (!rx_valid && n < 200) begin
         @(negedge clk);
         if (!ss) ss_low++;
         n++;
      end
      check("single_rx_valid", 32'(rx_valid), 32'd1);
      // rx_valid is set on the 67th edge after the accept edge, i.e. the
      // 68th cycle counting the accept cycle as cycle 0.
      check("single_latency", 32'(cyc - t0), 32'd67);
      check("single_ss_low", 32'(ss_low), 32'd67);
      check("single_rx_data", 32'(rx_data), 32'h3C);
      check("single_mosi_at_rises", 32'(cap), 32'hA5);
      check("single_rise_count", 32'(rise_cnt), 32'd8);
      check("single_ready_on_done", {30'd0, ss, tx_ready}, 32'b11);
      @(negedge clk);
      check("single_pulse_width", 32'(rx_valid), 32'd0);
      repeat (3) @(negedge clk);

      // ---- back-to-back 0x01 then 0xFF, slave returns 0x6B ----
      sbyte    = 8'h6B;
      tx_data  = 8'h01;
      tx_valid = 1'b1;
      pulses = 0;
      @(negedge clk);
      n = 0;
      while (!rx_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("b2b_first_valid", 32'(rx_valid), 32'd1);
      if (rx_valid) pulses++;
      check("b2b_first_mosi", 32'(cap), 32'h01);
      check("b2b_first_rx", 32'(rx_data), 32'h6B);
      check("b2b_ss_high", 32'(ss), 32'd1);
      tx_data = 8'hFF;
      @(negedge clk);
      tx_valid = 1'b0;
      check("b2b_second_accepted", {30'd0, ss, busy}, 32'b01);
      n = 0;
      while (n < 150) begin
         @(negedge clk);
         if (rx_valid) begin
            pulses++;
            check("b2b_second_mosi", 32'(cap), 32'hFF);
            check("b2b_second_rx", 32'(rx_data), 32'h6B);
         end
         n++;
      end
      check("b2b_pulses", 32'(pulses), 32'd2);

      // ---- busy ignore: 0x55 offered during SHIFT ----
      sbyte    = 8'h0F;
      tx_data  = 8'hC3;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      n = 0;
      while (!sclk && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("busy_in_shift", {30'd0, sclk, tx_ready}, 32'b10);
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      repeat (3) @(negedge clk);
      tx_valid = 1'b0;
      pulses = 0;
      n = 0;
      while (n < 150) begin
         @(negedge clk);
         if (rx_valid) begin
            pulses++;
            check("busy_mosi", 32'(cap), 32'hC3);
            check("busy_rx", 32'(rx_data), 32'h0F);
         end
         n++;
      end
      check("busy_pulses", 32'(pulses), 32'd1);
      check("busy_idle_after", {30'd0, ss, busy}, 32'b10);

      // ---- reset after the 4th sclk rise ----
      sbyte    = 8'h81;
      tx_data  = 8'h5A;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      n = 0;
      while (rise_cnt != 4'd4 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("abort_reached_rise4", {30'd0, sclk, ss}, 32'b10);
      rst = 1'b0;
      #1;
      check("abort_async", {28'd0, ss, sclk, mosi, busy}, 32'b1000);
      @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rx_valid) pulses++;
      end
      check("abort_no_valid", 32'(pulses), 32'd0);
      check("abort_rx_data", 32'(rx_data), 32'h00);
      sbyte    = 8'hE7;
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      n = 0;
      while (!rx_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("after_abort_valid", 32'(rx_valid), 32'd1);
      check("after_abort_rx", 32'(rx_data), 32'hE7);
      check("after_abort_mosi", 32'(cap), 32'h3C);

      // ---- divide-by-1 loopback, 0x96 ----
      tx_data1  = 8'h96;
      tx_valid1 = 1'b1;
      @(negedge clk);
      t0 = cyc;
      tx_valid1 = 1'b0;
      n = 0;
      while (!rx_valid1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("fast_valid", 32'(rx_valid1), 32'd1);
      check("fast_latency", 32'(cyc - t0), 32'd17);
      check("fast_rx", 32'(rx_data1), 32'h96);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
